lvdc_io_port_bank: RTL

//  Parametrised CPU-side I/O port bank for the LVDC I/O bus. Decodes io_addr during nIOR/nIOW strobes.
//  - Write path: NCH output latches (574-style: data committed at the strobe's rising edge).
//  - Read path: drives NCH synchronised input ports and the readback registers onto the data bus.
//  - Adds per-channel change-detect interrupts with mask and status, which the fixed GPIO latch/buffer pair lacks.

---
 rtl/lvdc_io_pkg.sv | 25 ++
 rtl/lvdc_sync2.sv | 29 ++
 rtl/lvdc_io_port_bank.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lvdc_io_pkg.sv
// Register-map helpers for the LVDC I/O port bank.
// The map is laid out relative to BASE_ADDR as:
//   OUT[0..NCH-1], IN[0..NCH-1], IRQ_STAT, IRQ_MASK
// so every offset is a function of the channel count.
package lvdc_io_pkg;

  localparam int OFF_OUT0 = 0;

  function automatic int off_out(input int k);
    return OFF_OUT0 + k;
  endfunction

  function automatic int off_in(input int nch, input int k);
    return nch + k;
  endfunction

  function automatic int off_irq_stat(input int nch);
    return 2 * nch;
  endfunction

  function automatic int off_irq_mask(input int nch);
    return 2 * nch + 1;
  endfunction

endpackage

// File: rtl/lvdc_sync2.sv
// Two-flop synchroniser for asynchronous inputs, any width.
// Ports:
//   clk   - destination clock
//   rstb  - asynchronous active-low reset; both flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronised output (2 clock edges of latency)
module lvdc_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lvdc_io_port_bank.sv
// CPU-side I/O port bank for the LVDC I/O bus.
// Decodes io_addr while the synchronised nIOR/nIOW strobes are low.
// Writes land in NCH output latches (committed when nIOW rises), reads
// return the output latches, the synchronised input ports or the
// interrupt status/mask. Each input channel raises a sticky change flag.
// Ports:
//   clk, rstb        - clock, asynchronous active-low reset
//   io_addr          - CPU address, stable for the whole strobe
//   nior, niow       - asynchronous active-low read / write strobes
//   db_in            - inbound data bus
//   db_out, db_oe    - registered outbound data and its drive enable
//   int_inhibit      - forces interrupt low while 1
//   port_in          - NCH asynchronous input words, channel k at [k*DATA_W +: DATA_W]
//   port_out         - NCH latched output words
//   interrupt        - registered level interrupt
//   strobe_err       - one-cycle pulse when both strobes are low together
module lvdc_io_port_bank
  import lvdc_io_pkg::*;
#(
  parameter int                DATA_W    = 26,
  parameter int                NCH       = 4,
  parameter int                ADDR_W    = 13,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h020,
  parameter logic [DATA_W-1:0] OUT_RESET = '0
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [ADDR_W-1:0]     io_addr,
  input  logic                  nior,
  input  logic                  niow,
  input  logic [DATA_W-1:0]     db_in,
  output logic [DATA_W-1:0]     db_out,
  output logic                  db_oe,
  input  logic                  int_inhibit,
  input  logic [NCH*DATA_W-1:0] port_in,
  output logic [NCH*DATA_W-1:0] port_out,
  output logic                  interrupt,
  output logic                  strobe_err
);

  logic [1:0]            strb_s;
  logic                  r_s, w_s, w_s_d;
  logic [NCH*DATA_W-1:0] in_s, in_prev;
  logic                  wr_rise, ovl, ovl_d, wr_cancel;
  logic [ADDR_W-1:0]     wr_addr_p0, rd_off, wr_off;
  logic [DATA_W-1:0]     wr_data_p0, rd_word;
  logic                  commit_vld_p1;
  logic                  rd_hit, stat_we, mask_we;
  logic [NCH-1:0]        out_we, in_chg, stat_clr;
  logic [NCH-1:0]        irq_stat, irq_mask;

  // Stage s: strobes and input ports enter the clock domain
  lvdc_sync2 #(.WIDTH(2), .RST_VAL(2'b11)) u_sync_strb (
    .clk (clk), .rstb (rstb), .d ({nior, niow}), .q (strb_s)
  );

  lvdc_sync2 #(.WIDTH(NCH*DATA_W), .RST_VAL('0)) u_sync_in (
    .clk (clk), .rstb (rstb), .d (port_in), .q (in_s)
  );

  assign r_s     = strb_s[1];
  assign w_s     = strb_s[0];
  assign wr_rise = w_s & ~w_s_d;
  assign ovl     = ~r_s & ~w_s;
  assign rd_off  = io_addr - BASE_ADDR;
  assign wr_off  = wr_addr_p0 - BASE_ADDR;

  always_comb begin
    rd_hit  = 1'b0;
    rd_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_off == ADDR_W'(off_out(k))) begin
        rd_hit  = 1'b1;
        rd_word = port_out[k*DATA_W +: DATA_W];
      end
      if (rd_off == ADDR_W'(off_in(NCH, k))) begin
        rd_hit  = 1'b1;
        rd_word = in_s[k*DATA_W +: DATA_W];
      end
    end
    if (rd_off == ADDR_W'(off_irq_stat(NCH))) begin
      rd_hit  = 1'b1;
      rd_word = DATA_W'(irq_stat);
    end
    if (rd_off == ADDR_W'(off_irq_mask(NCH))) begin
      rd_hit  = 1'b1;
      rd_word = DATA_W'(irq_mask);
    end
  end

  always_comb begin
    out_we  = '0;
    stat_we = 1'b0;
    mask_we = 1'b0;
    if (commit_vld_p1) begin
      for (int k = 0; k < NCH; k++)
        if (wr_off == ADDR_W'(off_out(k))) out_we[k] = 1'b1;
      stat_we = (wr_off == ADDR_W'(off_irq_stat(NCH)));
      mask_we = (wr_off == ADDR_W'(off_irq_mask(NCH)));
    end
    stat_clr = stat_we ? wr_data_p0[NCH-1:0] : '0;
    for (int k = 0; k < NCH; k++)
      in_chg[k] = |(in_s[k*DATA_W +: DATA_W] ^ in_prev[k*DATA_W +: DATA_W]);
  end

  // Stage p0: sample address/data during the write strobe, track overlap.
  // A write that ever overlapped a read is dropped when its strobe ends.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      w_s_d         <= 1'b1;
      wr_addr_p0    <= '0;
      wr_data_p0    <= '0;
      wr_cancel     <= 1'b0;
      commit_vld_p1 <= 1'b0;
      ovl_d         <= 1'b0;
      strobe_err    <= 1'b0;
    end else begin
      w_s_d <= w_s;
      if (!w_s) begin
        wr_addr_p0 <= io_addr;
        wr_data_p0 <= db_in;
      end
      if (ovl)          wr_cancel <= 1'b1;
      else if (wr_rise) wr_cancel <= 1'b0;
      // Stage p1: commit request, applied to the target on the next edge
      commit_vld_p1 <= wr_rise & ~wr_cancel;
      ovl_d         <= ovl;
      strobe_err    <= ovl & ~ovl_d;
    end
  end

  // Read drive: refreshed every cycle of a clean, decoded read strobe
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      db_out <= '0;
      db_oe  <= 1'b0;
    end else if (!r_s && w_s && rd_hit) begin
      db_out <= rd_word;
      db_oe  <= 1'b1;
    end else begin
      db_oe  <= 1'b0;
    end
  end

  // Stage p2: register file and interrupt; a new change beats a W1C clear
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      port_out  <= {NCH{OUT_RESET}};
      irq_stat  <= '0;
      irq_mask  <= '0;
      in_prev   <= '0;
      interrupt <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++)
        if (out_we[k]) port_out[k*DATA_W +: DATA_W] <= wr_data_p0;
      if (mask_we) irq_mask <= wr_data_p0[NCH-1:0];
      irq_stat  <= (irq_stat & ~stat_clr) | in_chg;
      in_prev   <= in_s;
      interrupt <= (|(irq_stat & irq_mask)) & ~int_inhibit;
    end
  end

endmodule
